wb_rr_arbiter: RTL and testbench
================================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2: number of Wishbone master ports, range 2..8.
REQ-002 SHALL have parameter DW, default 64: data width; byte-select width is DW/8.
REQ-003 SHALL have parameter AW, default 64: address width.
REQ-004 SHALL have parameter TIMEOUT, default 255: stall cycles before abort; 0 disables the watchdog.
REQ-005 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 m_cyc_i, m_stb_i, m_we_i  input  N_MASTERS each  per-master bus-cycle, strobe and write.
REQ-008 m_adr_i  input  N_MASTERS*AW  flattened; master i occupies slice [i*AW +: AW].
REQ-009 m_dat_i  input  N_MASTERS*DW; m_sel_i  input  N_MASTERS*DW/8; m_cti_i  input  N_MASTERS*3; m_bte_i  input  N_MASTERS*2.
REQ-010 m_ack_o, m_err_o, m_rty_o  output  N_MASTERS each  per-master terminations.
REQ-011 m_dat_o  output  DW  read data, shared by all masters.
REQ-012 s_cyc_o, s_stb_o, s_we_o  output  1; s_adr_o  output  AW; s_dat_o  output  DW; s_sel_o  output  DW/8; s_cti_o  output  3; s_bte_o  output  2.
REQ-013 s_ack_i, s_err_i, s_rty_i  input  1; s_dat_i  input  DW.
REQ-014 grant_o  output  N_MASTERS  one-hot owner, registered; timeout_o  output  1  one-cycle abort pulse.

Function
REQ-015 SHALL implement FSM states IDLE, OWN and ABORT.
REQ-016 In IDLE, when any m_cyc_i bit is high, SHALL grant the first requester at or after rr_ptr (wrapping N_MASTERS-1 -> 0), register grant_o, and enter OWN at the next edge.
REQ-017 Grant latency SHALL be exactly 1 cycle: request seen in cycle n gives s_cyc_o high in cycle n+1.
REQ-018 In OWN, s_* SHALL combinationally equal the owner's cyc/stb/we/adr/dat/sel/cti/bte; m_dat_o SHALL equal s_dat_i at all times.
REQ-019 m_ack_o/m_err_o/m_rty_o SHALL forward s_*_i to the owner bit only; non-owner bits SHALL stay 0.
REQ-020 Ownership SHALL persist across multiple strobes and cti bursts (010 incrementing, 111 end) while owner m_cyc_i stays high.
REQ-021 Owner m_cyc_i low in OWN -> IDLE at the next edge; rr_ptr := (owner+1) mod N_MASTERS; grant_o := 0.
REQ-022 s_cyc_o SHALL be low for at least one cycle between consecutive owners, including on release with other requests pending.
REQ-023 Watchdog counter SHALL increment each OWN cycle with s_stb_o high and no s_ack_i/s_err_i/s_rty_i, and clear on any termination or state exit.
REQ-024 Counter reaching TIMEOUT (nonzero) -> ABORT: in that cycle s_cyc_o/s_stb_o = 0, owner m_err_o = 1, timeout_o = 1, all other outputs idle.
REQ-025 ABORT SHALL last exactly 1 cycle, then IDLE, with rr_ptr advanced per REQ-021.
REQ-026 A slave termination arriving in the ABORT cycle SHALL be ignored.
REQ-027 Owner m_cyc_i already low in the cycle the counter reaches TIMEOUT: release (REQ-021) SHALL take priority; no ABORT.
REQ-028 Requests from non-owners in OWN SHALL neither be acknowledged nor change the grant.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, rr_ptr = 0, counter = 0, grant_o = 0, timeout_o = 0, and all s_cyc_o/s_stb_o/m_ack_o/m_err_o/m_rty_o = 0, including mid-burst.
REQ-030 After rst rises, the first arbitration SHALL favour master 0.

Verification
REQ-031 Masters 0 and 1 raise cyc in the same cycle after reset -> grant_o = 01 next cycle; after master 0 drops cyc, one idle cycle, then grant_o = 10.
REQ-032 Master 1 performs a 4-beat burst (cti 010,010,010,111) with 1-wait-state acks -> four m_ack_o[1] pulses, m_ack_o[0] stays 0, s_cyc_o continuous.
REQ-033 TIMEOUT = 4, slave never terminates -> m_err_o[owner] and timeout_o high together on the 4th stalled cycle; s_cyc_o low that cycle; IDLE after.
REQ-034 N_MASTERS = 4, all requesting continuously for 8 cycles each -> grants 0,1,2,3,0 in order.
REQ-035 rst asserted mid-burst -> all outputs 0 in the same cycle without a clock edge; after release, master 2 alone requests -> granted in 1 cycle.
REQ-036 TIMEOUT = 0 with stalled slave for 1000 cycles -> no m_err_o, timeout_o stays 0, owner retained.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave port, with a stall watchdog
// that aborts a hung cycle by returning an error to the owning master.
module wb_rr_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned DW        = 64,
  parameter int unsigned AW        = 64,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_cyc_i,
  input  logic [N_MASTERS-1:0]          m_stb_i,
  input  logic [N_MASTERS-1:0]          m_we_i,
  input  logic [N_MASTERS*AW-1:0]       m_adr_i,
  input  logic [N_MASTERS*DW-1:0]       m_dat_i,
  input  logic [N_MASTERS*(DW/8)-1:0]   m_sel_i,
  input  logic [N_MASTERS*3-1:0]        m_cti_i,
  input  logic [N_MASTERS*2-1:0]        m_bte_i,
  output logic [N_MASTERS-1:0]          m_ack_o,
  output logic [N_MASTERS-1:0]          m_err_o,
  output logic [N_MASTERS-1:0]          m_rty_o,
  output logic [DW-1:0]                 m_dat_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  input  logic [DW-1:0]                 s_dat_i,
  output logic [N_MASTERS-1:0]          grant_o,
  output logic                          timeout_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StOwn, StAbort} state_e;

  state_e               state_q;
  logic [PW-1:0]        owner_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [31:0]          cnt_q;
  logic                 timeout_q;

  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  int unsigned          cand;
  logic [PW-1:0]        cand_w;

  // First requester at or after rr_ptr_q, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_w     = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_MASTERS) cand = cand - N_MASTERS;
      cand_w = cand[PW-1:0];
      if (!pick_valid && m_cyc_i[cand_w]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_w;
      end
    end
  end

  int unsigned          own_i;
  logic                 own;
  logic                 owner_cyc;
  logic                 owner_stb;
  logic                 term;
  logic                 stall;
  logic [N_MASTERS-1:0] owner_oh;
  logic [N_MASTERS-1:0] pick_oh;
  logic [PW-1:0]        next_ptr;

  assign own_i     = 32'(owner_q);
  assign own       = (state_q == StOwn);
  assign owner_cyc = m_cyc_i[owner_q];
  assign owner_stb = m_stb_i[owner_q];
  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign stall     = own && owner_cyc && owner_stb && !term;
  assign owner_oh  = {{(N_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  assign pick_oh   = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
  assign next_ptr  = (owner_q == PW'(N_MASTERS - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (own) begin
      s_cyc_o = owner_cyc;
      s_stb_o = owner_stb;
      s_we_o  = m_we_i[owner_q];
      s_adr_o = m_adr_i[own_i*AW +: AW];
      s_dat_o = m_dat_i[own_i*DW +: DW];
      s_sel_o = m_sel_i[own_i*SW +: SW];
      s_cti_o = m_cti_i[own_i*3 +: 3];
      s_bte_o = m_bte_i[own_i*2 +: 2];
      m_ack_o = owner_oh & {N_MASTERS{s_ack_i}};
      m_err_o = owner_oh & {N_MASTERS{s_err_i}};
      m_rty_o = owner_oh & {N_MASTERS{s_rty_i}};
    end else if (state_q == StAbort) begin
      // Slave terminations are ignored here; only the abort error is returned.
      m_err_o = owner_oh;
    end
  end

  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= pick_oh;
            state_q <= StOwn;
          end
        end
        StOwn: begin
          if (!owner_cyc) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= next_ptr;
            cnt_q    <= '0;
          end else if (stall && (TIMEOUT != 0) && (cnt_q + 32'd2 >= TIMEOUT)) begin
            // Next cycle is the TIMEOUT-th stalled one and becomes the abort cycle.
            state_q   <= StAbort;
            grant_q   <= '0;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else if (stall) begin
            if (TIMEOUT != 0) cnt_q <= cnt_q + 32'd1;
          end else if (term) begin
            cnt_q <= '0;
          end
        end
        StAbort: begin
          state_q  <= StIdle;
          rr_ptr_q <= next_ptr;
          cnt_q    <= '0;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench: a 4-master TIMEOUT=4 arbiter for arbitration, bursts, abort and reset,
// plus a default 2-master TIMEOUT=0 arbiter for the disabled-watchdog case.
module tb_wb_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instance A: 4 masters, 32-bit, TIMEOUT=4
  logic [3:0]   a_cyc, a_stb, a_we, a_ack_m, a_err_m, a_rty_m, a_grant;
  logic [127:0] a_adr, a_dat;
  logic [15:0]  a_sel;
  logic [11:0]  a_cti;
  logic [7:0]   a_bte;
  logic [31:0]  a_mdat, a_sadr, a_sdat_o, a_sdat_i;
  logic [3:0]   a_ssel;
  logic [2:0]   a_scti;
  logic [1:0]   a_sbte;
  logic         a_scyc, a_sstb, a_swe, a_ack, a_err, a_rty, a_tmo;

  wb_rr_arbiter #(.N_MASTERS(4), .DW(32), .AW(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_adr_i(a_adr), .m_dat_i(a_dat),
    .m_sel_i(a_sel), .m_cti_i(a_cti), .m_bte_i(a_bte),
    .m_ack_o(a_ack_m), .m_err_o(a_err_m), .m_rty_o(a_rty_m), .m_dat_o(a_mdat),
    .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe), .s_adr_o(a_sadr), .s_dat_o(a_sdat_o),
    .s_sel_o(a_ssel), .s_cti_o(a_scti), .s_bte_o(a_sbte),
    .s_ack_i(a_ack), .s_err_i(a_err), .s_rty_i(a_rty), .s_dat_i(a_sdat_i),
    .grant_o(a_grant), .timeout_o(a_tmo)
  );

  // Instance B: defaults except TIMEOUT=0
  logic [1:0]   b_cyc, b_stb, b_we, b_ack_m, b_err_m, b_rty_m, b_grant;
  logic [127:0] b_adr, b_dat;
  logic [15:0]  b_sel;
  logic [5:0]   b_cti;
  logic [3:0]   b_bte;
  logic [63:0]  b_mdat, b_sadr, b_sdat_o, b_sdat_i;
  logic [7:0]   b_ssel;
  logic [2:0]   b_scti;
  logic [1:0]   b_sbte;
  logic         b_scyc, b_sstb, b_swe, b_tmo;

  wb_rr_arbiter #(.TIMEOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_adr_i(b_adr), .m_dat_i(b_dat),
    .m_sel_i(b_sel), .m_cti_i(b_cti), .m_bte_i(b_bte),
    .m_ack_o(b_ack_m), .m_err_o(b_err_m), .m_rty_o(b_rty_m), .m_dat_o(b_mdat),
    .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe), .s_adr_o(b_sadr), .s_dat_o(b_sdat_o),
    .s_sel_o(b_ssel), .s_cti_o(b_scti), .s_bte_o(b_sbte),
    .s_ack_i(1'b0), .s_err_i(1'b0), .s_rty_i(1'b0), .s_dat_i(b_sdat_i),
    .grant_o(b_grant), .timeout_o(b_tmo)
  );

  typedef struct packed {
    logic [3:0]  cyc;
    logic        ack;
    logic        err;
    logic [3:0]  grant;
    logic [3:0]  mack;
    logic [3:0]  merr;
    logic        scyc;
    logic        tmo;
    logic [31:0] sadr;
  } vec_t;

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hA000_0001;

  vec_t vecs[24];

  function automatic int oh2idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int held;
    int ng;
    int order[5];
    int exp_order[5];
    int wait_n;
    logic gap_bad, b_err_seen, b_tmo_seen, b_lost;

    // cyc ack err | grant mack merr scyc tmo sadr
    vecs[0]  = '{4'b0011, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, A0};
    vecs[2]  = '{4'b0010, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, A0};
    vecs[3]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};
    // master 1 burst with one wait state per beat, master 0 requesting meanwhile
    for (int i = 4; i < 12; i += 2) begin
      vecs[i]   = '{4'b0011, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, A1};
      vecs[i+1] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0, A1};
    end
    vecs[12] = '{4'b0001, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, A1};
    vecs[13] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};
    for (int i = 14; i < 17; i++)
      vecs[i] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, A0};
    vecs[17] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 32'h0};
    vecs[18] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[19] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, A0};
    vecs[20] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, A0};
    vecs[21] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, A0};
    vecs[22] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, A0};
    vecs[23] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};

    a_cyc = '0; a_stb = '0; a_we = 4'b0010; a_ack = 0; a_err = 0; a_rty = 0;
    a_adr = {32'hA000_0003, 32'hA000_0002, A1, A0};
    a_dat = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    a_sel = 16'hF31C; a_cti = {3'b000, 3'b000, 3'b010, 3'b111}; a_bte = 8'h1B;
    a_sdat_i = 32'h5A5A_0001;
    b_cyc = '0; b_stb = '0; b_we = 2'b01;
    b_adr = {64'hB000_0000_0000_0001, 64'hB000_0000_0000_0000};
    b_dat = {64'h1111, 64'h2222}; b_sel = 16'h3CF0; b_cti = '0; b_bte = '0;
    b_sdat_i = 64'hCAFE_F00D_1234_5678;

    repeat (3) @(posedge clk);
    #1;
    check("reset grant", {60'd0, a_grant}, 64'h0);
    check("reset timeout", {63'd0, a_tmo}, 64'h0);
    check("reset s_cyc", {63'd0, a_scyc}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      a_cyc = vecs[i].cyc; a_stb = vecs[i].cyc; a_ack = vecs[i].ack; a_err = vecs[i].err;
      @(negedge clk);
      check($sformatf("row%0d grant", i), {60'd0, a_grant}, {60'd0, vecs[i].grant});
      check($sformatf("row%0d m_ack", i), {60'd0, a_ack_m}, {60'd0, vecs[i].mack});
      check($sformatf("row%0d m_err", i), {60'd0, a_err_m}, {60'd0, vecs[i].merr});
      check($sformatf("row%0d m_rty", i), {60'd0, a_rty_m}, 64'h0);
      check($sformatf("row%0d s_cyc", i), {63'd0, a_scyc}, {63'd0, vecs[i].scyc});
      check($sformatf("row%0d timeout", i), {63'd0, a_tmo}, {63'd0, vecs[i].tmo});
      check($sformatf("row%0d s_adr", i), {32'd0, a_sadr}, {32'd0, vecs[i].sadr});
      if (i == 5) begin
        check("burst s_cti", {61'd0, a_scti}, 64'h2);
        check("burst s_we", {63'd0, a_swe}, 64'h1);
        check("burst s_dat", {32'd0, a_sdat_o}, 64'hD1);
        check("burst s_sel", {60'd0, a_ssel}, 64'h1);
        check("burst s_bte", {62'd0, a_sbte}, 64'h2);
      end
    end
    check("m_dat_o", {32'd0, a_mdat}, {32'd0, a_sdat_i});

    // Asynchronous reset in the middle of an owned, acknowledged cycle
    @(posedge clk); #1;
    a_cyc = 4'b0001; a_stb = 4'b0001; a_ack = 1'b0;
    @(posedge clk); #1;
    a_ack = 1'b1;
    #1;
    check("pre-reset m_ack", {60'd0, a_ack_m}, 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst grant", {60'd0, a_grant}, 64'h0);
    check("async rst s_cyc/s_stb", {62'd0, a_scyc, a_sstb}, 64'h0);
    check("async rst m_ack/err/rty", {52'd0, a_ack_m, a_err_m, a_rty_m}, 64'h0);
    check("async rst timeout", {63'd0, a_tmo}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    a_cyc = 4'b0100; a_stb = 4'b0100; a_ack = 1'b0;
    @(posedge clk); #1;
    check("post-reset m2 grant", {60'd0, a_grant}, 64'h4);
    check("post-reset m2 s_cyc", {63'd0, a_scyc}, 64'h1);

    // Fresh reset, then all four masters request; each holds 8 cycles
    @(negedge clk);
    a_cyc = '0; a_stb = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_order = '{0, 1, 2, 3, 0};
    held = 0; ng = 0; gap_bad = 1'b0;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      @(posedge clk); #1;
      a_cyc = 4'hF;
      if (a_grant == 4'h0) begin
        held = 0;
      end else begin
        if (held == 0) begin
          order[ng] = oh2idx(a_grant);
          ng++;
        end
        held++;
        if (held == 8) a_cyc = ~a_grant;
      end
      @(negedge clk);
      if (a_grant == 4'h0 && a_scyc) gap_bad = 1'b1;
    end
    check("rotation grant count", 64'(ng), 64'd5);
    for (int g = 0; g < 5; g++)
      if (g < ng) check($sformatf("rotation grant %0d", g), 64'(order[g]), 64'(exp_order[g]));
    check("rotation idle gap", {63'd0, gap_bad}, 64'h0);
    @(posedge clk); #1;
    a_cyc = '0; a_stb = '0;

    // Disabled watchdog: master 0 stalls forever on instance B
    b_cyc = 2'b01; b_stb = 2'b01;
    wait_n = 0;
    while (b_grant != 2'b01 && wait_n < 4) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("B grant latency", 64'(wait_n), 64'd1);
    @(negedge clk);
    check("B s_adr", b_sadr, 64'hB000_0000_0000_0000);
    check("B s_sel", {56'd0, b_ssel}, 64'hF0);
    check("B m_dat_o", b_mdat, b_sdat_i);
    b_err_seen = 1'b0; b_tmo_seen = 1'b0; b_lost = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (b_err_m != 2'b00) b_err_seen = 1'b1;
      if (b_tmo) b_tmo_seen = 1'b1;
      if (b_grant != 2'b01 || !b_scyc) b_lost = 1'b1;
    end
    check("B no m_err", {63'd0, b_err_seen}, 64'h0);
    check("B no timeout", {63'd0, b_tmo_seen}, 64'h0);
    check("B owner retained", {63'd0, b_lost}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
